// File: rtl/seq_detector_fsm_pkg.sv
// rtl/seq_detector_fsm_pkg.sv - shared types and helpers for the programmable sequence detector
//
// Package seq_det_pkg
//   state_t     : FSM encoding (IDLE/FILL/HUNT; 2'd3 is unused and recovers to IDLE)
//   len_w()     : width of a field that can hold 0..max_len
//   clamp_len() : limits a loaded pattern length to max_len
//   len_mask()  : low-order ones mask selecting the active pattern bits
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 8;

  // Masks are built at this fixed width and truncated by the caller,
  // so MAX_LEN may not exceed it.
  localparam int MASK_W = 32;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEFAULT_LEN_W = len_w(DEFAULT_MAX_LEN);

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_fsm_if.sv
// rtl/seq_detector_fsm_if.sv - serial stream, configuration and status bundle for the detector
//
// Signals
//   In1, In_valid                          serial bit and its qualifier
//   Cfg_load, Cfg_pattern, Cfg_len,
//   Cfg_overlap                            run-time pattern configuration
//   Cnt_clr                                match counter clear
//   Out1, Match_cnt, State                 match pulse, saturating count, FSM state
// Modports
//   master : drives stream/config, observes status
//   slave  : the detector
interface seq_detector_fsm_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W
);
  localparam int LEN_W = len_w(MAX_LEN);

  logic               In1;
  logic               In_valid;
  logic               Cfg_load;
  logic [MAX_LEN-1:0] Cfg_pattern;
  logic [LEN_W-1:0]   Cfg_len;
  logic               Cfg_overlap;
  logic               Cnt_clr;
  logic               Out1;
  logic [CNT_W-1:0]   Match_cnt;
  logic [1:0]         State;

  modport master (
    output In1, In_valid, Cfg_load, Cfg_pattern, Cfg_len, Cfg_overlap, Cnt_clr,
    input  Out1, Match_cnt, State
  );

  modport slave (
    input  In1, In_valid, Cfg_load, Cfg_pattern, Cfg_len, Cfg_overlap, Cnt_clr,
    output Out1, Match_cnt, State
  );

endinterface

// File: rtl/seq_detector_fsm_sat_counter.sv
// rtl/seq_detector_fsm_sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports
//   CLK  in  1      clock
//   RST  in  1      synchronous active-high reset
//   inc  in  1      count one event
//   clr  in  1      force count to 0 (wins over inc)
//   cnt  out CNT_W  current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_fsm.sv
// rtl/seq_detector_fsm.sv - programmable serial sequence detector with match pulse and count
//
// Ports
//   CLK  in  1  clock, all logic on posedge
//   RST  in  1  synchronous active-high reset
//   bus  slave modport of seq_detector_fsm_if:
//        In1/In_valid stream in; Cfg_* loaded on Cfg_load; Cnt_clr clears count;
//        Out1 one-cycle registered match pulse; Match_cnt saturating; State debug.
module seq_detector_fsm
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input logic              CLK,
  input logic              RST,
  seq_detector_fsm_if.slave bus
);

  localparam int LEN_W = len_w(MAX_LEN);

  state_t             state_q, state_d;
  // The oldest history bit is shifted out before it could ever be compared,
  // so only MAX_LEN-1 bits are kept; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               overlap_q, overlap_d;
  logic               out_q, out_d;

  logic               match;
  logic               full;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;  // extra bit so fill+1 cannot wrap
  logic [LEN_W-1:0]   load_len;

  assign window   = {hist_q, bus.In1};
  assign mask     = MAX_LEN'(len_mask(int'(len_q)));
  assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign load_len = LEN_W'(clamp_len(int'(bus.Cfg_len), MAX_LEN));

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    out_d     = 1'b0;
    match     = 1'b0;
    full      = 1'b0;

    if (bus.Cfg_load) begin
      // A load restarts detection; any bit presented this cycle is dropped.
      pattern_d = bus.Cfg_pattern;
      len_d     = load_len;
      overlap_d = bus.Cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = (load_len == '0) ? IDLE : FILL;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FILL, HUNT: begin
          if (bus.In_valid) begin
            full    = (fill_inc >= {1'b0, len_q});
            hist_d  = window[MAX_LEN-2:0];
            fill_d  = full ? len_q : fill_inc[LEN_W-1:0];
            state_d = full ? HUNT : FILL;
            if (full && (((window ^ pattern_q) & mask) == '0)) begin
              match = 1'b1;
              out_d = 1'b1;
              if (!overlap_q) begin
                // Non-overlapping: the matched bits may not seed the next match.
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      out_q     <= out_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (match),
    .clr (bus.Cnt_clr),
    .cnt (bus.Match_cnt)
  );

  assign bus.Out1  = out_q;
  assign bus.State = state_q;

endmodule
